sd_card_detect_ctrl: RTL and testbench
======================================

// Module: sd_card_detect_ctrl
//
// PURPOSE
//   Front-end controller for SD socket status pins in the SDHC core, in one clock domain.
//   Synchronizes the asynchronous card-detect and write-protect pins (2 stages) and
//   debounces card-detect. Sequences slot power-up and card-clock enable, and raises
//   insert/remove interrupt pulses to the host register block.
//
// PARAMETERS
//   CNT_W        20     width of the shared debounce/power-up counter
//   DEBOUNCE_CYC 50000  cycles a new card-detect level must hold before acceptance (1..2^CNT_W-1)
//   PWRUP_CYC    25000  cycles pwr_en is held before clk_en/card_present assert (1..2^CNT_W-1)
//
// PORTS
//   clk          in   1  core clock
//   rst          in   1  synchronous reset, active-high
//   cd_n         in   1  async card-detect pin, 0 = card inserted
//   wp           in   1  async write-protect pin
//   soft_eject   in   1  host one-cycle pulse: power card down while still inserted
//   wp_sync      out  1  write-protect, 2-stage synchronized, not debounced
//   card_present out  1  debounced, powered card ready for use
//   pwr_en       out  1  slot power switch enable
//   clk_en       out  1  SD clock gate enable
//   insert_irq   out  1  one-cycle pulse on entry to READY
//   remove_irq   out  1  one-cycle pulse on loss of READY/DEB_OUT (removal or eject)
//
// BEHAVIOUR
//   Sync: cd_n and wp each pass 2 flops with reset inside this block.
//     Reset values: cd stage = absent, wp stage = 0. pres = ~cd_n synced; latency 2 clk.
//   Reset: state=EMPTY, cnt=0; all outputs 0. Reset mid-operation drops power and clock in
//     the next cycle with no irq. After reset release, a present card re-runs debounce.
//   FSM (cnt cleared on every state change):
//     EMPTY   : pres=1 -> DEB_IN.
//     DEB_IN  : pres=0 -> EMPTY. Else cnt++; cnt==DEBOUNCE_CYC-1 -> PWRUP.
//     PWRUP   : pwr_en=1. pres=0 -> EMPTY (power off, no irq).
//               Else cnt++; cnt==PWRUP_CYC-1 -> READY.
//     READY   : pwr_en=clk_en=card_present=1. insert_irq=1 in the first READY cycle only.
//               soft_eject -> HOLD. pres=0 -> DEB_OUT.
//     DEB_OUT : outputs as READY, no insert_irq. pres=1 -> READY (glitch ignored, no irq).
//               soft_eject -> HOLD. Else cnt++; cnt==DEBOUNCE_CYC-1 -> EMPTY.
//     HOLD    : all power/clock outputs 0. pres=0 -> EMPTY with no further irq.
//               soft_eject ignored.
//   Leaving READY/DEB_OUT to EMPTY or HOLD asserts remove_irq for exactly 1 cycle (the first
//     cycle in the new state). pwr_en/clk_en/card_present fall in that same cycle.
//   Simultaneous soft_eject and pres=0 in READY: eject wins -> HOLD, single remove_irq.
//   soft_eject outside READY/DEB_OUT has no effect.
//   Counter compares are equality on CNT_W bits. cnt never exceeds max(DEBOUNCE_CYC, PWRUP_CYC)-1,
//     so no wrap-around.
//   insert_irq and remove_irq are never high in the same cycle. All outputs are registered.
//
// TESTING (DEBOUNCE_CYC=4, PWRUP_CYC=3)
//   1 Insert: cd_n 1->0 held. pwr_en rises 2+1+4 clk after the edge; clk_en, card_present
//     and a 1-cycle insert_irq follow 3 clk later.
//   2 Bounce: cd_n low for 2 clk then high during DEB_IN -> back to EMPTY, pwr_en never 1.
//     Same glitch in READY -> no remove_irq, outputs stay 1.
//   3 Remove: cd_n 0->1 held in READY. remove_irq pulses once and all outputs are 0 at
//     2+1+4 clk after the edge.
//   4 Eject: soft_eject in READY -> next cycle pwr_en=0 with remove_irq=1. Then cd_n->1 gives
//     EMPTY with no second irq. Eject and removal in the same cycle -> exactly one remove_irq.
//   5 Reset mid-PWRUP: rst=1 for 1 clk. All outputs 0 next cycle. With the card still
//     inserted, full insert sequence repeats, insert_irq once.
//   6 wp: toggle wp -> wp_sync follows after exactly 2 clk in every state, independent of FSM.

Source files
------------

// File: rtl/sd_card_detect_ctrl_if.sv
// Signal bundle between the SD socket/host side and the card-detect controller.
// slave  : the controller (takes socket pins and host eject, drives status/irq)
// master : whatever drives the pins and consumes the status (host side / testbench)
interface sd_card_detect_ctrl_if;
  logic cd_n;
  logic wp;
  logic soft_eject;
  logic wp_sync;
  logic card_present;
  logic pwr_en;
  logic clk_en;
  logic insert_irq;
  logic remove_irq;

  modport master (
    output cd_n,
    output wp,
    output soft_eject,
    input  wp_sync,
    input  card_present,
    input  pwr_en,
    input  clk_en,
    input  insert_irq,
    input  remove_irq
  );

  modport slave (
    input  cd_n,
    input  wp,
    input  soft_eject,
    output wp_sync,
    output card_present,
    output pwr_en,
    output clk_en,
    output insert_irq,
    output remove_irq
  );
endinterface

// File: rtl/sd_card_detect_ctrl.sv
// SD socket front end: synchronizes card-detect / write-protect pins, debounces
// card-detect, sequences slot power and card clock, and raises insert/remove pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// EMPTY   | no card seen, slot unpowered
// DEB_IN  | card-detect asserted, waiting for it to hold DEBOUNCE_CYC cycles
// PWRUP   | slot powered, waiting PWRUP_CYC cycles before enabling the clock
// READY   | card powered, clocked and reported present
// DEB_OUT | card-detect dropped while ready, waiting for it to hold
// HOLD    | host ejected the card; unpowered until it is physically removed
module sd_card_detect_ctrl #(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int PWRUP_CYC    = 25000
) (
  input logic                 clk,
  input logic                 rst,
  sd_card_detect_ctrl_if.slave sd
);

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    DEB_IN  = 3'd1,
    PWRUP   = 3'd2,
    READY   = 3'd3,
    DEB_OUT = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic cd_s1, cd_s2;
  logic wp_s1, wp_s2;
  logic pres;

  logic card_present_q, pwr_en_q, clk_en_q, insert_irq_q, remove_irq_q;

  // Two-flop synchronizers; card-detect resets to "absent" (pin high).
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_s1 <= 1'b1;
      cd_s2 <= 1'b1;
      wp_s1 <= 1'b0;
      wp_s2 <= 1'b0;
    end else begin
      cd_s1 <= sd.cd_n;
      cd_s2 <= cd_s1;
      wp_s1 <= sd.wp;
      wp_s2 <= wp_s1;
    end
  end

  assign pres = ~cd_s2;

  // State and shared debounce/power-up counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic; the counter restarts on every state change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      EMPTY: begin
        if (pres) state_nxt = DEB_IN;
      end
      DEB_IN: begin
        if (!pres)                 state_nxt = EMPTY;
        else if (cnt == DEB_LAST)  state_nxt = PWRUP;
        else                       cnt_nxt   = cnt + CNT_W'(1);
      end
      PWRUP: begin
        if (!pres)                 state_nxt = EMPTY;
        else if (cnt == PWR_LAST)  state_nxt = READY;
        else                       cnt_nxt   = cnt + CNT_W'(1);
      end
      READY: begin
        // Eject takes priority over a simultaneous removal.
        if (sd.soft_eject)         state_nxt = HOLD;
        else if (!pres)            state_nxt = DEB_OUT;
      end
      DEB_OUT: begin
        if (sd.soft_eject)         state_nxt = HOLD;
        else if (pres)             state_nxt = READY;
        else if (cnt == DEB_LAST)  state_nxt = EMPTY;
        else                       cnt_nxt   = cnt + CNT_W'(1);
      end
      HOLD: begin
        if (!pres) state_nxt = EMPTY;
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      card_present_q <= 1'b0;
      pwr_en_q       <= 1'b0;
      clk_en_q       <= 1'b0;
      insert_irq_q   <= 1'b0;
      remove_irq_q   <= 1'b0;
    end else begin
      pwr_en_q       <= (state_nxt == PWRUP) || (state_nxt == READY) || (state_nxt == DEB_OUT);
      clk_en_q       <= (state_nxt == READY) || (state_nxt == DEB_OUT);
      card_present_q <= (state_nxt == READY) || (state_nxt == DEB_OUT);
      // Only a fresh power-up counts as an insertion; returning from DEB_OUT does not.
      insert_irq_q   <= (state == PWRUP) && (state_nxt == READY);
      remove_irq_q   <= ((state == READY) || (state == DEB_OUT)) &&
                        ((state_nxt == EMPTY) || (state_nxt == HOLD));
    end
  end

  assign sd.wp_sync      = wp_s2;
  assign sd.card_present = card_present_q;
  assign sd.pwr_en       = pwr_en_q;
  assign sd.clk_en       = clk_en_q;
  assign sd.insert_irq   = insert_irq_q;
  assign sd.remove_irq   = remove_irq_q;

endmodule

// File: tb/tb_sd_card_detect_ctrl.sv
// Directed bench for sd_card_detect_ctrl with short debounce/power-up times.
// Expected output words are queued as each step is driven and popped per cycle.
module tb_sd_card_detect_ctrl;

  // {wp_sync, card_present, pwr_en, clk_en, insert_irq, remove_irq}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_PWR  = 6'b001000;
  localparam logic [5:0] O_RDY  = 6'b011100;
  localparam logic [5:0] O_INS  = 6'b011110;
  localparam logic [5:0] O_REM  = 6'b000001;
  localparam logic [5:0] O_WP   = 6'b100000;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  sd_card_detect_ctrl_if sd ();

  sd_card_detect_ctrl #(
    .CNT_W       (20),
    .DEBOUNCE_CYC(4),
    .PWRUP_CYC   (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sd (sd.slave)
  );

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t       e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = {sd.wp_sync, sd.card_present, sd.pwr_en, sd.clk_en, sd.insert_irq, sd.remove_irq};
    n_chk++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
    end
  endtask

  // Queue n cycles of the same expected word, then step and compare each one.
  task automatic expect_n(input int n, input string tag, input logic [5:0] val);
    for (int i = 0; i < n; i++) sb.push_back('{tag, val});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_one();
    end
  endtask

  // Full insertion from EMPTY: 2 sync + 1 + 4 debounce, then 3 power-up cycles.
  task automatic insert_seq(input string tag);
    sd.cd_n = 1'b0;
    expect_n(6, {tag, "_deb"}, O_NONE);
    expect_n(3, {tag, "_pwrup"}, O_PWR);
    expect_n(1, {tag, "_irq"}, O_INS);
    expect_n(2, {tag, "_ready"}, O_RDY);
  endtask

  initial begin
    rst           = 1'b1;
    sd.cd_n       = 1'b1;
    sd.wp         = 1'b1;
    sd.soft_eject = 1'b0;
    @(negedge clk);
    expect_n(3, "reset", O_NONE);

    // wp sync latency out of reset
    rst = 1'b0;
    expect_n(1, "wp_rise_lat1", O_NONE);
    expect_n(2, "wp_rise_lat2", O_WP);
    sd.wp = 1'b0;
    expect_n(1, "wp_fall_lat1", O_WP);
    expect_n(2, "wp_fall_lat2", O_NONE);

    // 1: insert
    insert_seq("insert");

    // 2: glitch in READY -> no remove
    sd.cd_n = 1'b1;
    expect_n(2, "ready_glitch_a", O_RDY);
    sd.cd_n = 1'b0;
    expect_n(8, "ready_glitch_b", O_RDY);

    // 6: wp in READY
    sd.wp = 1'b1;
    expect_n(1, "wp_ready_lat1", O_RDY);
    expect_n(2, "wp_ready_lat2", O_RDY | O_WP);
    sd.wp = 1'b0;
    expect_n(1, "wp_ready_fall1", O_RDY | O_WP);
    expect_n(1, "wp_ready_fall2", O_RDY);

    // 3: removal
    sd.cd_n = 1'b1;
    expect_n(6, "remove_deb", O_RDY);
    expect_n(1, "remove_irq", O_REM);
    expect_n(3, "remove_empty", O_NONE);

    // 2: bounce during DEB_IN
    sd.cd_n = 1'b0;
    expect_n(2, "debin_glitch_a", O_NONE);
    sd.cd_n = 1'b1;
    expect_n(10, "debin_glitch_b", O_NONE);

    // soft_eject in EMPTY has no effect
    sd.soft_eject = 1'b1;
    expect_n(1, "eject_empty", O_NONE);
    sd.soft_eject = 1'b0;
    expect_n(2, "eject_empty_after", O_NONE);

    // 4: eject, then physical removal
    insert_seq("ins2");
    sd.soft_eject = 1'b1;
    expect_n(1, "eject_irq", O_REM);
    sd.soft_eject = 1'b0;
    expect_n(3, "hold", O_NONE);
    sd.soft_eject = 1'b1;
    expect_n(1, "eject_in_hold", O_NONE);
    sd.soft_eject = 1'b0;
    sd.cd_n = 1'b1;
    expect_n(10, "hold_remove", O_NONE);

    // 4: eject and removal in the same cycle
    insert_seq("ins3");
    sd.cd_n = 1'b1;
    expect_n(2, "both_pre", O_RDY);
    sd.soft_eject = 1'b1;
    expect_n(1, "both_irq", O_REM);
    sd.soft_eject = 1'b0;
    expect_n(6, "both_after", O_NONE);

    // 5: reset mid-PWRUP with card still inserted
    sd.cd_n = 1'b0;
    expect_n(6, "rst_deb", O_NONE);
    expect_n(2, "rst_pwrup", O_PWR);
    rst = 1'b1;
    expect_n(1, "rst_drop", O_NONE);
    rst = 1'b0;
    insert_seq("reinsert");
    expect_n(4, "reinsert_hold", O_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
